// File: rtl/uov_run_pkg.sv
// Shared codes for the UOV run controller: command ops, response status,
// core function selects and the controller FSM state encoding.
package uov_run_pkg;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;

  localparam logic [1:0] STAT_OK      = 2'd0;
  localparam logic [1:0] STAT_TIMEOUT = 2'd1;
  localparam logic [1:0] STAT_BAD_CMD = 2'd2;

  localparam logic [2:0] KEYGEN           = 3'd0;
  localparam logic [2:0] SIGN             = 3'd1;
  localparam logic [2:0] VRFY             = 3'd2;
  localparam logic [2:0] SEND_INSTRUCTION = 3'd3;
  localparam logic [2:0] IDLE_FN          = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHK    = 3'd1,
    ST_RST    = 3'd2,
    ST_L_RD   = 3'd3,
    ST_L_SET  = 3'd4,
    ST_L_STB  = 3'd5,
    ST_R_WAIT = 3'd6,
    ST_RESP   = 3'd7
  } run_state_e;

endpackage

// File: rtl/uov_run_timeout.sv
// Cycle counter for the RUN wait: clear, count while enabled, and flag the
// enabled cycle that reaches the limit. A zero limit never expires.
module uov_run_timeout #(
  parameter int TO_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // Compared one bit wider so a limit of all-ones cannot wrap to a match.
  assign expired = en && (limit != '0) &&
                   (({1'b0, cnt_q} + (TO_W+1)'(1)) == {1'b0, limit});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uov_run_ctrl.sv
// Host-side sequencer for one uov core: programs instruction memory through
// the strobed message word and runs keygen/sign/vrfy with reset and timeout.
module uov_run_ctrl
  import uov_run_pkg::*;
#(
  parameter int INST_LEN   = 32,
  parameter int INST_DEPTH = 1024,
  parameter int CYC_W      = 31,
  parameter int TO_W       = 32,
  parameter int SETUP      = 2,
  parameter int HOLD       = 2,
  parameter int RST_CYC    = 3,
  localparam int AW        = $clog2(INST_DEPTH),
  localparam int PW        = INST_LEN + AW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  // Both handshakes: a transfer happens on a rising clk edge where valid and
  // ready are high together; the sender holds payload stable until then.
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [2:0]          cmd_state,
  input  logic [AW-1:0]       cmd_addr,
  input  logic [AW:0]         cmd_len,
  input  logic [TO_W-1:0]     cmd_timeout,
  output logic [AW-1:0]       src_rd_addr,
  input  logic [INST_LEN-1:0] src_rd_data,
  output logic [2:0]          core_state,
  output logic [AW-1:0]       core_inst_addr,
  output logic                core_rst_n,
  output logic [PW-1:0]       core_prog,
  input  logic                core_done,
  input  logic [CYC_W-1:0]    core_cycles,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_status,
  output logic [CYC_W-1:0]    rsp_cycles,
  output logic                busy,
  output run_state_e          dbg_state
);

  localparam int PH_W = 16;
  localparam int LE_W = AW + 2;

  run_state_e          state_q, state_d;
  logic [1:0]          cmd_op_q, cmd_op_d;
  logic [2:0]          cmd_fn_q, cmd_fn_d;
  logic [AW-1:0]       cmd_addr_q, cmd_addr_d;
  logic [AW:0]         cmd_len_q, cmd_len_d;
  logic [TO_W-1:0]     cmd_to_q, cmd_to_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [AW:0]         rem_q, rem_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic                done_q, done_d;
  logic [AW-1:0]       src_rd_addr_q, src_rd_addr_d;
  logic [2:0]          core_state_q, core_state_d;
  logic [AW-1:0]       core_inst_addr_q, core_inst_addr_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic [PW-1:0]       core_prog_q, core_prog_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [1:0]          rsp_status_q, rsp_status_d;
  logic [CYC_W-1:0]    rsp_cycles_q, rsp_cycles_d;
  logic                busy_q, busy_d;

  logic [LE_W-1:0]     load_end;
  logic                cmd_bad;
  logic                to_expired;

  uov_run_timeout #(.TO_W(TO_W)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == ST_RST),
    .en      (state_q == ST_R_WAIT),
    .limit   (cmd_to_q),
    .expired (to_expired)
  );

  assign load_end = {2'b00, cmd_addr_q} + {1'b0, cmd_len_q};
  assign cmd_bad  = (cmd_op_q > OP_RUN) ||
                    ((cmd_op_q == OP_RUN) && (cmd_fn_q > VRFY)) ||
                    ((cmd_op_q == OP_LOAD) && (load_end > LE_W'(INST_DEPTH)));

  always_comb begin
    state_d          = state_q;
    cmd_op_d         = cmd_op_q;
    cmd_fn_d         = cmd_fn_q;
    cmd_addr_d       = cmd_addr_q;
    cmd_len_d        = cmd_len_q;
    cmd_to_d         = cmd_to_q;
    addr_d           = addr_q;
    rem_d            = rem_q;
    ph_d             = ph_q;
    done_d           = done_q;
    src_rd_addr_d    = src_rd_addr_q;
    core_state_d     = core_state_q;
    core_inst_addr_d = core_inst_addr_q;
    core_rst_n_d     = core_rst_n_q;
    core_prog_d      = core_prog_q;
    rsp_valid_d      = rsp_valid_q;
    rsp_status_d     = rsp_status_q;
    rsp_cycles_d     = rsp_cycles_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_op_d   = cmd_op;
          cmd_fn_d   = cmd_state;
          cmd_addr_d = cmd_addr;
          cmd_len_d  = cmd_len;
          cmd_to_d   = cmd_timeout;
          state_d    = ST_CHK;
        end
      end
      ST_CHK: begin
        if (cmd_bad) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = STAT_BAD_CMD;
          rsp_cycles_d = '0;
          state_d      = ST_RESP;
        end else if ((cmd_op_q == OP_LOAD) && (cmd_len_q == '0)) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = STAT_OK;
          rsp_cycles_d = '0;
          state_d      = ST_RESP;
        end else begin
          core_state_d     = (cmd_op_q == OP_LOAD) ? SEND_INSTRUCTION : cmd_fn_q;
          core_inst_addr_d = (cmd_op_q == OP_LOAD) ? '0 : cmd_addr_q;
          core_rst_n_d     = 1'b0;
          ph_d             = '0;
          addr_d           = cmd_addr_q;
          rem_d            = cmd_len_q;
          src_rd_addr_d    = (cmd_op_q == OP_LOAD) ? cmd_addr_q : src_rd_addr_q;
          state_d          = ST_RST;
        end
      end
      ST_RST: begin
        if (ph_q == PH_W'(RST_CYC - 1)) begin
          core_rst_n_d = 1'b1;
          done_d       = core_done;
          ph_d         = '0;
          state_d      = (cmd_op_q == OP_LOAD) ? ST_L_RD : ST_R_WAIT;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_L_RD: begin
        // src_rd_addr has pointed at addr_q for at least a cycle, so the data is valid.
        core_prog_d = {1'b0, addr_q, src_rd_data};
        ph_d        = '0;
        state_d     = ST_L_SET;
      end
      ST_L_SET: begin
        if (ph_q == PH_W'(SETUP - 1)) begin
          core_prog_d = {1'b1, core_prog_q[PW-2:0]};
          ph_d        = '0;
          state_d     = ST_L_STB;
          // Prefetch the next source word while the strobe is held.
          if (rem_q > (AW+1)'(1)) begin
            src_rd_addr_d = addr_q + AW'(1);
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_L_STB: begin
        if (ph_q == PH_W'(HOLD - 1)) begin
          core_prog_d = {1'b0, core_prog_q[PW-2:0]};
          ph_d        = '0;
          addr_d      = addr_q + AW'(1);
          rem_d       = rem_q - (AW+1)'(1);
          if (rem_q == (AW+1)'(1)) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = STAT_OK;
            rsp_cycles_d = '0;
            state_d      = ST_RESP;
          end else begin
            state_d = ST_L_RD;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_R_WAIT: begin
        done_d = core_done;
        if (core_done && !done_q) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = STAT_OK;
          rsp_cycles_d = core_cycles;
          state_d      = ST_RESP;
        end else if (to_expired) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = STAT_TIMEOUT;
          rsp_cycles_d = '0;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      cmd_op_q         <= '0;
      cmd_fn_q         <= '0;
      cmd_addr_q       <= '0;
      cmd_len_q        <= '0;
      cmd_to_q         <= '0;
      addr_q           <= '0;
      rem_q            <= '0;
      ph_q             <= '0;
      done_q           <= 1'b0;
      src_rd_addr_q    <= '0;
      core_state_q     <= IDLE_FN;
      core_inst_addr_q <= '0;
      core_rst_n_q     <= 1'b1;
      core_prog_q      <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_status_q     <= '0;
      rsp_cycles_q     <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cmd_op_q         <= cmd_op_d;
      cmd_fn_q         <= cmd_fn_d;
      cmd_addr_q       <= cmd_addr_d;
      cmd_len_q        <= cmd_len_d;
      cmd_to_q         <= cmd_to_d;
      addr_q           <= addr_d;
      rem_q            <= rem_d;
      ph_q             <= ph_d;
      done_q           <= done_d;
      src_rd_addr_q    <= src_rd_addr_d;
      core_state_q     <= core_state_d;
      core_inst_addr_q <= core_inst_addr_d;
      core_rst_n_q     <= core_rst_n_d;
      core_prog_q      <= core_prog_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_status_q     <= rsp_status_d;
      rsp_cycles_q     <= rsp_cycles_d;
      busy_q           <= busy_d;
    end
  end

  assign cmd_ready      = (state_q == ST_IDLE);
  assign src_rd_addr    = src_rd_addr_q;
  assign core_state     = core_state_q;
  assign core_inst_addr = core_inst_addr_q;
  assign core_rst_n     = core_rst_n_q;
  assign core_prog      = core_prog_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_status     = rsp_status_q;
  assign rsp_cycles     = rsp_cycles_q;
  assign busy           = busy_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_uov_run_ctrl.sv
// Bench for uov_run_ctrl: directed scenarios plus randomized commands checked
// against a command-level model of latency, response and programming words.
module tb_uov_run_ctrl;
  import uov_run_pkg::*;

  localparam int INST_LEN = 32;
  localparam int DEPTH    = 1024;
  localparam int AW       = 10;
  localparam int CYC_W    = 31;
  localparam int TO_W     = 32;
  localparam int SETUP    = 2;
  localparam int HOLD     = 2;
  localparam int RST_CYC  = 3;
  localparam int PW       = INST_LEN + AW + 1;
  localparam int W        = 2 + CYC_W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [1:0]          cmd_op = '0;
  logic [2:0]          cmd_state = '0;
  logic [AW-1:0]       cmd_addr = '0;
  logic [AW:0]         cmd_len = '0;
  logic [TO_W-1:0]     cmd_timeout = '0;
  logic [AW-1:0]       src_rd_addr;
  logic [INST_LEN-1:0] src_rd_data = '0;
  logic [2:0]          core_state;
  logic [AW-1:0]       core_inst_addr;
  logic                core_rst_n;
  logic [PW-1:0]       core_prog;
  logic                core_done = 1'b0;
  logic [CYC_W-1:0]    core_cycles = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [1:0]          rsp_status;
  logic [CYC_W-1:0]    rsp_cycles;
  logic                busy;
  run_state_e          dbg_state;

  uov_run_ctrl #(
    .INST_LEN(INST_LEN), .INST_DEPTH(DEPTH), .CYC_W(CYC_W), .TO_W(TO_W),
    .SETUP(SETUP), .HOLD(HOLD), .RST_CYC(RST_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_state(cmd_state), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_timeout(cmd_timeout),
    .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .core_state(core_state), .core_inst_addr(core_inst_addr),
    .core_rst_n(core_rst_n), .core_prog(core_prog),
    .core_done(core_done), .core_cycles(core_cycles),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_cycles(rsp_cycles), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- source memory (1-cycle read latency) ----------------
  logic [INST_LEN-1:0] src_mem [DEPTH];
  always @(posedge clk) src_rd_data <= src_mem[src_rd_addr];

  // ---------------- programming-word monitor ----------------
  logic [AW+INST_LEN-1:0] strb_q [$];
  int   setup_err = 0;
  int   hold_err  = 0;
  int   same_lo   = 0;
  logic [PW-1:0] prev_prog = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      same_lo   = 0;
      prev_prog = '0;
    end else begin
      if (core_prog[PW-1] && !prev_prog[PW-1]) begin
        strb_q.push_back(core_prog[PW-2:0]);
        if (same_lo < SETUP) setup_err++;
      end
      if (core_prog[PW-1] && prev_prog[PW-1] && core_prog[PW-2:0] != prev_prog[PW-2:0])
        hold_err++;
      if (!core_prog[PW-1])
        same_lo = (core_prog[PW-2:0] == prev_prog[PW-2:0] && !prev_prog[PW-1]) ? same_lo + 1 : 1;
      prev_prog = core_prog;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int m_state  = 7;   // last core function driven, as the model sees it
  int m_addr   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_core_rst_n"}, core_rst_n, 1);
    check({tag, "_core_state"}, core_state, 7);
    check({tag, "_inst_addr"}, core_inst_addr, 0);
    check({tag, "_core_prog"}, core_prog, 0);
    check({tag, "_src_rd_addr"}, src_rd_addr, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_status"}, rsp_status, 0);
    check({tag, "_rsp_cycles"}, rsp_cycles, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic fill_src(input int addr, input int len);
    for (int i = addr; i < addr + len && i < DEPTH; i++) src_mem[i] = $urandom;
  endtask

  // ---------------- driver: one full command incl. core model ----------------
  // done_at: R_WAIT cycle (1-based) in which the core raises done.
  // stale: done is already high on entry and stays high for R_WAIT cycles 1..3.
  task automatic do_cmd(input int op, input int st, input int addr, input int len,
                        input int to, input int done_at, input int cyc_val,
                        input bit stale, input int hold);
    int exp_lat, decide, lat, wcyc, rst_len, prog_chg, g;
    bit bad, zero, got, seen_low;
    logic [1:0]       st_exp;
    logic [CYC_W-1:0] cy_exp;
    logic [W-1:0]     e;
    logic [PW-1:0]    last_prog;
    logic [AW-1:0]    a;
    bad  = (op > 1) || (op == 1 && st > 2) || (op == 0 && addr + len > DEPTH);
    zero = !bad && op == 0 && len == 0;
    decide = 0;
    cy_exp = '0;
    if (bad) begin
      st_exp = STAT_BAD_CMD; exp_lat = 1;
    end else if (zero) begin
      st_exp = STAT_OK; exp_lat = 1;
    end else if (op == 0) begin
      st_exp = STAT_OK; exp_lat = 1 + RST_CYC + len * (1 + SETUP + HOLD);
      m_state = 3; m_addr = 0;
    end else begin
      m_state = st; m_addr = addr;
      if (to != 0 && to < done_at) begin
        st_exp = STAT_TIMEOUT; decide = to;
      end else begin
        st_exp = STAT_OK; cy_exp = CYC_W'(cyc_val); decide = done_at;
      end
      exp_lat = 1 + RST_CYC + decide;
    end
    exp_q.push_back({st_exp, cy_exp});
    strb_q.delete();
    setup_err = 0;
    hold_err  = 0;
    core_done   = stale;
    core_cycles = CYC_W'(cyc_val);
    cmd_op      = 2'(op);
    cmd_state   = 3'(st);
    cmd_addr    = AW'(addr);
    cmd_len     = (AW+1)'(len);
    cmd_timeout = TO_W'(to);
    cmd_valid   = 1'b1;
    g = 0;
    while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
    check("cmd_ready_wait", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ready_low_after_accept", cmd_ready, 0);
    lat = 0; wcyc = 0; seen_low = 0; rst_len = 0; prog_chg = 0; got = 0;
    last_prog = core_prog;
    while (!got && lat < 3000) begin
      if (rsp_valid) got = 1;
      else begin
        if (!core_rst_n) begin rst_len++; seen_low = 1; end
        else if (seen_low) wcyc++;
        if (core_prog !== last_prog) prog_chg++;
        last_prog = core_prog;
        if (op == 1) core_done = (wcyc != 0 && wcyc >= done_at) || (stale && wcyc <= 3);
        @(negedge clk);
        lat++;
      end
    end
    e = exp_q.pop_front();
    check("rsp_seen", got, 1);
    if (!got) begin
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      m_state = 7; m_addr = 0; core_done = 1'b0;
      return;
    end
    check("rsp_latency", lat, exp_lat);
    check("rsp_status", rsp_status, e[W-1:CYC_W]);
    check("rsp_cycles", rsp_cycles, e[CYC_W-1:0]);
    check("core_state", core_state, m_state);
    check("core_inst_addr", core_inst_addr, m_addr);
    check("rst_pulse_len", rst_len, (bad || zero) ? 0 : RST_CYC);
    if (op == 0 && !bad && !zero) begin
      check("strobe_count", strb_q.size(), len);
      for (int i = 0; i < len && i < strb_q.size(); i++) begin
        a = AW'(addr + i);
        check("strobe_word", strb_q[i], {a, src_mem[addr + i]});
      end
      check("strobe_setup", setup_err, 0);
      check("strobe_hold", hold_err, 0);
    end else begin
      check("prog_untouched", prog_chg, 0);
      check("no_strobe", strb_q.size(), 0);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_hold_valid", rsp_valid, 1);
      check("rsp_hold_data", {rsp_status, rsp_cycles}, e);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    core_done = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("idle_ready", cmd_ready, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r, op, st, addr, len, to, dat, hold;
    bit stale;
    int g;
    for (int i = 0; i < DEPTH; i++) src_mem[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_dbg_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) src_mem[i] = INST_LEN'(32'hA0 + i);
    do_cmd(0, 0, 0, 4, 0, 0, 0, 0, 1);              // LOAD 4 words from 0
    do_cmd(0, 0, 1020, 5, 0, 0, 0, 0, 0);           // out of range
    fill_src(1020, 4);
    do_cmd(0, 0, 1020, 4, 0, 0, 0, 0, 0);           // exactly reaches the end
    do_cmd(0, 0, 100, 0, 0, 0, 0, 0, 0);            // zero length
    do_cmd(1, 1, 134, 0, 0, 500, 12345, 0, 2);      // RUN sign
    do_cmd(1, 0, 20, 0, 0, 12, 777, 1, 0);          // stale done
    do_cmd(1, 2, 5, 0, 50, 1000, 4242, 0, 0);       // timeout, no done
    do_cmd(1, 2, 5, 0, 50, 50, 999, 0, 0);          // done on the timeout cycle
    do_cmd(1, 3, 7, 0, 0, 5, 1, 0, 0);              // illegal function
    do_cmd(3, 0, 7, 0, 0, 5, 1, 0, 0);              // illegal op
    fill_src(500, 2);
    do_cmd(0, 0, 500, 2, 0, 0, 0, 0, 10);           // response held 10 cycles

    // Reset in the middle of the second word of a LOAD.
    fill_src(10, 4);
    cmd_op = OP_LOAD; cmd_addr = AW'(10); cmd_len = (AW+1)'(4); cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    strb_q.delete();
    g = 0;
    while (strb_q.size() < 2 && g < 200) begin @(negedge clk); g++; end
    check("mid_load_reached", strb_q.size() >= 2, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    m_state = 7; m_addr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_src(200, 3);
    do_cmd(0, 0, 200, 3, 0, 0, 0, 0, 0);

    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      hold = $urandom_range(0, 3);
      if (r < 4) begin
        len  = $urandom_range(0, 6);
        addr = ($urandom_range(0, 3) == 0) ? DEPTH - 1 - $urandom_range(0, 8)
                                           : $urandom_range(0, DEPTH - 1);
        fill_src(addr, len);
        do_cmd(0, 0, addr, len, 0, 0, 0, 0, hold);
      end else if (r < 8) begin
        st    = $urandom_range(0, 3);
        addr  = $urandom_range(0, DEPTH - 1);
        stale = $urandom_range(0, 1);
        dat   = stale ? $urandom_range(6, 60) : $urandom_range(1, 60);
        to    = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 60);
        do_cmd(1, st, addr, 0, to, dat, int'($urandom_range(0, 32'h7fff_ffff)), stale, hold);
      end else begin
        op = $urandom_range(2, 3);
        do_cmd(op, $urandom_range(0, 7), $urandom_range(0, DEPTH - 1),
               $urandom_range(0, 8), 0, 5, 1, 0, hold);
      end
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
